// File: rtl/rs_alu_issue_pkg.sv
// Shared definitions for the ALU reservation station: op-type encodings
// (identical to the ALU's), ROB tag width and ROB depth.
package rs_alu_issue_pkg;
  localparam int TAG_W    = 4;
  localparam int ROB_SIZE = 16;
  localparam int OP_W     = 6;

  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;
endpackage

// File: rtl/rs_prio_enc.sv
// Lowest-index priority encoder: idx is the position of the lowest set bit of vec.
module rs_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rs_alu_issue.sv
// ALU reservation station: holds ops until both operands are known, snoops the
// ALU/LSB broadcasts for wakeup, and issues one registered request per cycle.
module rs_alu_issue #(
  parameter int RS_SIZE = 8,
  parameter int TAG_W   = rs_alu_issue_pkg::TAG_W,
  parameter int OP_W    = rs_alu_issue_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             rob_clear,
  input  logic             issue_valid,
  input  logic [OP_W-1:0]  issue_op,
  input  logic [31:0]      issue_vj,
  input  logic [TAG_W-1:0] issue_qj,
  input  logic             issue_qj_busy,
  input  logic [31:0]      issue_vk,
  input  logic [TAG_W-1:0] issue_qk,
  input  logic             issue_qk_busy,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [31:0]      alu_cdb_data,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [31:0]      lsb_cdb_data,
  output logic             alu_mission,
  output logic [OP_W-1:0]  alu_op_type,
  output logic [31:0]      alu_rs1,
  output logic [31:0]      alu_rs2,
  output logic [TAG_W-1:0] alu_rob_dest
);
  import rs_alu_issue_pkg::*;

  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy, qj_busy, qk_busy, ready_vec;
  logic [OP_W-1:0]    op   [RS_SIZE];
  logic [31:0]        vj   [RS_SIZE];
  logic [31:0]        vk   [RS_SIZE];
  logic [TAG_W-1:0]   qj   [RS_SIZE];
  logic [TAG_W-1:0]   qk   [RS_SIZE];
  logic [TAG_W-1:0]   dest [RS_SIZE];
  logic [32:0]        wake_j [RS_SIZE];
  logic [32:0]        wake_k [RS_SIZE];
  logic [32:0]        byp_j, byp_k;
  logic [IDX_W-1:0]   free_idx, sel_idx;
  logic               free_found, sel_found;

  // Returns {pending, value} after snooping both broadcasts; ALU wins a tag tie.
  function automatic logic [32:0] snoop(input logic pend, input logic [TAG_W-1:0] tag,
                                        input logic [31:0] val);
    snoop = {pend, val};
    if (pend && alu_cdb_valid && alu_cdb_tag == tag)
      snoop = {1'b0, alu_cdb_data};
    else if (pend && lsb_cdb_valid && lsb_cdb_tag == tag)
      snoop = {1'b0, lsb_cdb_data};
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_vec[i] = busy[i] & ~qj_busy[i] & ~qk_busy[i];
      wake_j[i]    = snoop(qj_busy[i], qj[i], vj[i]);
      wake_k[i]    = snoop(qk_busy[i], qk[i], vk[i]);
    end
    byp_j = snoop(issue_qj_busy, issue_qj, issue_vj);
    byp_k = snoop(issue_qk_busy, issue_qk, issue_vk);
  end

  assign rs_full = &busy;

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .vec(~busy), .idx(free_idx), .found(free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_sel_enc (
    .vec(ready_vec), .idx(sel_idx), .found(sel_found)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= '0;
      alu_mission  <= 1'b0;
      alu_op_type  <= '0;
      alu_rs1      <= '0;
      alu_rs2      <= '0;
      alu_rob_dest <= '0;
    end else if (rob_clear) begin
      busy        <= '0;
      alu_mission <= 1'b0;
    end else if (!rdy) begin
      alu_mission <= 1'b0;
    end else begin
      // Wakeup writes all slots; free slots carry don't-care operand state.
      for (int i = 0; i < RS_SIZE; i++) begin
        {qj_busy[i], vj[i]} <= wake_j[i];
        {qk_busy[i], vk[i]} <= wake_k[i];
      end
      alu_mission <= sel_found;
      if (sel_found) begin
        busy[sel_idx] <= 1'b0;
        alu_op_type   <= op[sel_idx];
        alu_rs1       <= vj[sel_idx];
        alu_rs2       <= vk[sel_idx];
        alu_rob_dest  <= dest[sel_idx];
      end
      // Free slot is never the selected slot, so issue and dispatch cannot collide.
      if (issue_valid && !rs_full && free_found) begin
        busy[free_idx]              <= 1'b1;
        op[free_idx]                <= issue_op;
        qj[free_idx]                <= issue_qj;
        qk[free_idx]                <= issue_qk;
        dest[free_idx]              <= issue_dest;
        {qj_busy[free_idx], vj[free_idx]} <= byp_j;
        {qk_busy[free_idx], vk[free_idx]} <= byp_k;
      end
    end
  end
endmodule

// File: doc/rs_alu_issue.md
Name: rs_alu_issue

Overview:
Reservation station that is the initiator on the RS-to-ALU interface. It receives decoded ALU/branch/JALR ops from the issue stage and holds them until both operands are known. It snoops the ALU and LSB result broadcasts for operand wakeup. It dispatches at most one ready op per cycle to the combinational ALU as a registered, one-cycle request pulse.

Parameters:
RS_SIZE, 8, number of entries (power of two, 2..16)
TAG_W, 4, ROB tag width
OP_W, 6, op-type width (encodings from shared package)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global ready; low = stall
rob_clear  in  1  flush on mispredict
issue_valid  in  1  new op present this cycle
issue_op  in  OP_W  op type
issue_vj  in  32  operand 1 value (valid when issue_qj_busy=0)
issue_qj  in  TAG_W  ROB tag producing operand 1
issue_qj_busy  in  1  operand 1 pending
issue_vk  in  32  operand 2 value / immediate
issue_qk  in  TAG_W  ROB tag producing operand 2
issue_qk_busy  in  1  operand 2 pending
issue_dest  in  TAG_W  ROB entry of this op
rs_full  out  1  all entries busy
alu_cdb_valid  in  1  ALU broadcast (ALU finish)
alu_cdb_tag  in  TAG_W  ALU broadcast tag
alu_cdb_data  in  32  ALU broadcast value
lsb_cdb_valid  in  1  LSB broadcast
lsb_cdb_tag  in  TAG_W  LSB broadcast tag
lsb_cdb_data  in  32  LSB broadcast value
alu_mission  out  1  dispatch pulse to ALU
alu_op_type  out  OP_W  dispatched op
alu_rs1  out  32  operand 1
alu_rs2  out  32  operand 2
alu_rob_dest  out  TAG_W  dispatched ROB tag

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, sampled on the rising edge of clk.
- Reset state: all entry busy bits 0; alu_mission=0; alu_op_type=0, alu_rs1=0, alu_rs2=0, alu_rob_dest=0; rs_full=0.
- Entry fields: busy, op, vj, qj, qj_busy, vk, qk, qk_busy, dest. Pending flags are separate from tags, so tag 0 is a legal tag.
- Priority per edge: rst > rob_clear > !rdy > normal operation.
- rob_clear (rdy ignored): all busy bits cleared, alu_mission=0. The issue and dispatch requests of that cycle are dropped.
- rdy=0: entries, including captured operands, hold. CDB inputs and issue_valid are ignored. alu_mission is forced to 0 so the ALU never sees a duplicate request. The other alu_* outputs hold.
- rs_full: combinational AND of all busy bits.
- Issue: when issue_valid && !rs_full, write the lowest-index free entry. Issue while rs_full is silently dropped; the issuer must not do it.
- Issue-cycle bypass: if a pending source tag matches a valid CDB tag in the same cycle, the entry stores the CDB data with pending=0.
- Wakeup: each normal cycle, every busy entry with a pending source whose tag matches alu_cdb_tag (alu_cdb_valid) or lsb_cdb_tag (lsb_cdb_valid) captures the data and clears pending. If both CDBs carry the same tag (illegal), ALU data wins.
- Select: lowest-index busy entry with qj_busy=0 and qk_busy=0, evaluated on registered state at cycle start.
- Dispatch: on the next edge the selected entry is freed, alu_mission=1, and alu_op_type/alu_rs1/alu_rs2/alu_rob_dest are loaded from the entry. With no ready entry, alu_mission=0 and the data outputs hold.
- Latency:
  - Op issued ready at edge N is dispatched at edge N+1 (alu_mission high in cycle N+1).
  - Op woken at edge N is dispatched at edge N+1 at the earliest.
  - Same-cycle wakeup-and-dispatch is not supported.
- Simultaneous events: an entry freed by dispatch is not reusable in the same cycle. When full, issue is rejected even if a dispatch frees an entry that edge.
- The ALU is combinational. Its result appears on alu_cdb_* in the same cycle as alu_mission and is consumed at the next edge.

Decomposition:
- Shared package: op-type constants (LUI=1 ... AND=37, same encoding as the ALU), TAG_W, and the ROB-size constant.
- Sub-module rs_prio_enc: parameterised lowest-index priority encoder (vector in -> index out, found flag). Instantiated twice: free-slot search and ready-entry select.

Test Plan:
- Reset, then issue ADD (op 28), vj=5, vk=7, dest=3, both ready at edge 1 -> cycle 2: alu_mission=1, op=28, rs1=5, rs2=7, dest=3; cycle 3: alu_mission=0, rs_full=0.
- Issue SUB with qj=2 pending, vk=1; hold 3 cycles with no broadcast -> no dispatch. Then lsb_cdb_valid, tag=2, data=10 -> dispatch next cycle with rs1=10, rs2=1.
- Issue an op with qk=0 pending while alu_cdb_valid, tag=0, data=0xFFFF_FFFF in the same cycle -> entry stored ready; dispatch next cycle with rs2=0xFFFF_FFFF.
- Fill 8 entries, all pending on tag 6 -> rs_full=1 and a 9th issue is dropped. Broadcast tag 6 -> 8 consecutive dispatches in index order 0..7; rs_full falls after the first dispatch.
- With 3 ready entries, deassert rdy for 2 cycles -> alu_mission=0 and no entry freed. Reassert -> dispatches resume with none lost or duplicated.
- With 4 busy entries, assert rob_clear together with issue_valid -> next cycle all entries free, alu_mission=0, no later dispatch of the flushed or issued ops.
